// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator: one outstanding SRAM-like fetch, delivers {pc, instr} to ID,
// applies exception redirects and MIPS delay-slot branch redirects (immediate or deferred).
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_taken,
   input  logic [31:0] br_address,
   input  logic        br_ds_fetched,
   input  logic        exc_valid,
   input  logic [31:0] exc_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_addr_err,
   input  logic        id_ready
);

   typedef enum logic [1:0] {
      S_REQ       = 2'd0,
      S_WAIT_DATA = 2'd1,
      S_HOLD      = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   logic [31:0] pend_tgt;
   logic        pending;
   logic        discard;

   logic        pc_misaligned;
   logic        redirect_now;
   logic [31:0] redirect_tgt;
   logic        handshake;

   assign pc_misaligned = (fetch_pc[1:0] != 2'b00);
   assign inst_req      = (state == S_REQ) && !pc_misaligned;
   assign inst_addr     = fetch_pc;
   assign handshake     = (state == S_HOLD) && id_ready;

   // Exception beats an immediate branch redirect when both arrive together.
   assign redirect_now  = exc_valid || (br_taken && br_ds_fetched);
   assign redirect_tgt  = exc_valid ? exc_target : br_address;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_REQ;
         fetch_pc    <= RESET_PC;
         req_pc      <= '0;
         pend_tgt    <= '0;
         pending     <= 1'b0;
         discard     <= 1'b0;
         if_valid    <= 1'b0;
         if_pc       <= '0;
         if_instr    <= '0;
         if_addr_err <= 1'b0;
      end else begin
         unique case (state)
            S_REQ: begin
               if (pc_misaligned) begin
                  if (!redirect_now) begin
                     state       <= S_HOLD;
                     if_valid    <= 1'b1;
                     if_pc       <= fetch_pc;
                     if_instr    <= '0;
                     if_addr_err <= 1'b1;
                  end
               end else if (inst_addr_ok) begin
                  state    <= S_WAIT_DATA;
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + 32'd4;
               end
            end
            S_WAIT_DATA: begin
               if (inst_data_ok) begin
                  if (discard || redirect_now) begin
                     state   <= S_REQ;
                     discard <= 1'b0;
                  end else begin
                     state       <= S_HOLD;
                     if_valid    <= 1'b1;
                     if_pc       <= req_pc;
                     if_instr    <= inst_rdata;
                     if_addr_err <= 1'b0;
                  end
               end
            end
            S_HOLD: begin
               if (id_ready) begin
                  state    <= S_REQ;
                  if_valid <= 1'b0;
                  if (pending) begin
                     fetch_pc <= pend_tgt;
                     pending  <= 1'b0;
                  end
               end
            end
            default: state <= S_REQ;
         endcase

         // Redirect overlay: later assignments override the per-state updates above.
         if (redirect_now) begin
            fetch_pc <= redirect_tgt;
            pending  <= 1'b0;
            unique case (state)
               S_HOLD: begin
                  state    <= S_REQ;
                  if_valid <= 1'b0;
               end
               S_WAIT_DATA: begin
                  if (!inst_data_ok)
                     discard <= 1'b1;
               end
               S_REQ: begin
                  if (!pc_misaligned && inst_addr_ok)
                     discard <= 1'b1;
               end
               default: ;
            endcase
         end else if (br_taken) begin
            // Slot leaving ID this very cycle: no need to defer.
            if (handshake) begin
               fetch_pc <= br_address;
               pending  <= 1'b0;
            end else begin
               pending  <= 1'b1;
               pend_tgt <= br_address;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit with hand-computed expected values.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst_n;
   logic        br_taken;
   logic [31:0] br_address;
   logic        br_ds_fetched;
   logic        exc_valid;
   logic [31:0] exc_target;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_addr_err;
   logic        id_ready;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   fetch_pc_unit #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .br_taken     (br_taken),
      .br_address   (br_address),
      .br_ds_fetched(br_ds_fetched),
      .exc_valid    (exc_valid),
      .exc_target   (exc_target),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .if_instr     (if_instr),
      .if_addr_err  (if_addr_err),
      .id_ready     (id_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete fetch from REQ through delivery and ID handshake.
   task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word);
      check_eq("req",      {31'd0, inst_req}, 32'd1);
      check_eq("addr",     inst_addr, exp_addr);
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0;
      check_eq("wait_req", {31'd0, inst_req}, 32'd0);
      inst_data_ok = 1'b1;
      inst_rdata   = word;
      tick();
      inst_data_ok = 1'b0;
      check_eq("dl_valid", {31'd0, if_valid}, 32'd1);
      check_eq("dl_pc",    if_pc, exp_addr);
      check_eq("dl_instr", if_instr, word);
      check_eq("dl_err",   {31'd0, if_addr_err}, 32'd0);
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      check_eq("hs_valid", {31'd0, if_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] held_pc;
      logic [31:0] held_instr;
      rst_n         = 1'b0;
      br_taken      = 1'b0;
      br_address    = '0;
      br_ds_fetched = 1'b0;
      exc_valid     = 1'b0;
      exc_target    = '0;
      inst_addr_ok  = 1'b0;
      inst_data_ok  = 1'b0;
      inst_rdata    = '0;
      id_ready      = 1'b0;

      // Reset state
      repeat (3) tick();
      check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
      check_eq("rst_pc",    if_pc, 32'd0);
      check_eq("rst_instr", if_instr, 32'd0);
      check_eq("rst_err",   {31'd0, if_addr_err}, 32'd0);
      check_eq("rst_addr",  inst_addr, 32'hBFC0_0000);
      rst_n = 1'b1;

      // 1: sequential fetch
      fetch_one(32'hBFC0_0000, 32'h1111_0000);
      fetch_one(32'hBFC0_0004, 32'h1111_0004);
      fetch_one(32'hBFC0_0008, 32'h1111_0008);

      // 2: immediate branch redirect while held in ID
      check_eq("t2_addr", inst_addr, 32'hBFC0_000C);
      inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
      inst_data_ok = 1'b1; inst_rdata = 32'h2222_0000; tick(); inst_data_ok = 1'b0;
      check_eq("t2_hold_pc", if_pc, 32'hBFC0_000C);
      br_taken = 1'b1; br_ds_fetched = 1'b1; br_address = 32'h8000_0100;
      tick();
      br_taken = 1'b0; br_ds_fetched = 1'b0;
      check_eq("t2_valid", {31'd0, if_valid}, 32'd0);
      check_eq("t2_req",   {31'd0, inst_req}, 32'd1);
      check_eq("t2_tgt",   inst_addr, 32'h8000_0100);

      // 3: deferred branch, delay slot in flight
      fetch_one(32'h8000_0100, 32'h3333_0100);
      check_eq("t3_addr", inst_addr, 32'h8000_0104);
      inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
      br_taken = 1'b1; br_ds_fetched = 1'b0; br_address = 32'h8000_0200;
      tick();
      br_taken = 1'b0;
      check_eq("t3_wait_req", {31'd0, inst_req}, 32'd0);
      inst_data_ok = 1'b1; inst_rdata = 32'h3333_0104; tick(); inst_data_ok = 1'b0;
      check_eq("t3_slot_valid", {31'd0, if_valid}, 32'd1);
      check_eq("t3_slot_pc",    if_pc, 32'h8000_0104);
      check_eq("t3_slot_instr", if_instr, 32'h3333_0104);
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      check_eq("t3_req", {31'd0, inst_req}, 32'd1);
      check_eq("t3_tgt", inst_addr, 32'h8000_0200);

      // 4: exception while waiting for data -> data discarded
      inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
      exc_valid = 1'b1; exc_target = 32'hBFC0_0380;
      tick();
      exc_valid = 1'b0;
      check_eq("t4_wait_req", {31'd0, inst_req}, 32'd0);
      inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; tick(); inst_data_ok = 1'b0;
      check_eq("t4_drop_valid", {31'd0, if_valid}, 32'd0);
      check_eq("t4_req",        {31'd0, inst_req}, 32'd1);
      check_eq("t4_tgt",        inst_addr, 32'hBFC0_0380);
      fetch_one(32'hBFC0_0380, 32'h4444_0380);

      // 5: misaligned branch target
      br_taken = 1'b1; br_ds_fetched = 1'b1; br_address = 32'h8000_0102;
      tick();
      br_taken = 1'b0; br_ds_fetched = 1'b0;
      check_eq("t5_noreq", {31'd0, inst_req}, 32'd0);
      check_eq("t5_addr",  inst_addr, 32'h8000_0102);
      tick();
      check_eq("t5_valid", {31'd0, if_valid}, 32'd1);
      check_eq("t5_err",   {31'd0, if_addr_err}, 32'd1);
      check_eq("t5_pc",    if_pc, 32'h8000_0102);
      check_eq("t5_instr", if_instr, 32'd0);

      // 6: stall in HOLD, then simultaneous exception and branch
      held_pc    = if_pc;
      held_instr = if_instr;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("t6_valid", {31'd0, if_valid}, 32'd1);
         check_eq("t6_pc",    if_pc, held_pc);
         check_eq("t6_instr", if_instr, held_instr);
         check_eq("t6_noreq", {31'd0, inst_req}, 32'd0);
      end
      exc_valid = 1'b1; exc_target = 32'hBFC0_0380;
      br_taken = 1'b1; br_ds_fetched = 1'b1; br_address = 32'h8000_0300;
      tick();
      exc_valid = 1'b0; br_taken = 1'b0; br_ds_fetched = 1'b0;
      check_eq("t6_drop_valid", {31'd0, if_valid}, 32'd0);
      check_eq("t6_exc_wins",   inst_addr, 32'hBFC0_0380);
      fetch_one(32'hBFC0_0380, 32'h6666_0380);

      // Address wrap at top of space
      exc_valid = 1'b1; exc_target = 32'hFFFF_FFFC;
      tick();
      exc_valid = 1'b0;
      fetch_one(32'hFFFF_FFFC, 32'h7777_FFFC);
      check_eq("wrap_addr", inst_addr, 32'h0000_0000);

      // Deferred branch while the slot is held in ID
      inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
      inst_data_ok = 1'b1; inst_rdata = 32'h8888_0000; tick(); inst_data_ok = 1'b0;
      br_taken = 1'b1; br_ds_fetched = 1'b0; br_address = 32'h8000_0400;
      tick();
      br_taken = 1'b0;
      check_eq("pend_hold_valid", {31'd0, if_valid}, 32'd1);
      check_eq("pend_hold_pc",    if_pc, 32'h0000_0000);
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      check_eq("pend_tgt", inst_addr, 32'h8000_0400);
      check_eq("pend_req", {31'd0, inst_req}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
